// File: rtl/regfile_mp_pkg.sv
// Shared CPU definitions: register address width, architectural register
// indices used by decode, and the default packed read-address bundle.
package regfile_mp_pkg;
  localparam int REG_AW   = 5;
  localparam int REG_ZERO = 0;
  localparam int REG_RA   = 31;
  localparam int DEF_NRD  = 2;

  typedef logic [DEF_NRD-1:0][REG_AW-1:0] ra_bundle_t;
endpackage

// File: rtl/regfile_rd_mux.sv
// One read port: stored-value select, same-cycle write bypass (port 1 wins)
// and rbusy gating. Write enables arrive already qualified by the top.
module regfile_rd_mux
  import regfile_mp_pkg::*;
#(
  parameter int DW       = 32,
  parameter int DEPTH    = 32,
  parameter int AW       = 5,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic [DEPTH-1:0][DW-1:0] i_regs,
  input  logic [DEPTH-1:0]         i_busy,
  input  logic                     i_we0,
  input  logic [AW-1:0]            i_wa0,
  input  logic [DW-1:0]            i_wd0,
  input  logic                     i_we1,
  input  logic [AW-1:0]            i_wa1,
  input  logic [DW-1:0]            i_wd1,
  input  logic [AW-1:0]            i_ra,
  output logic [DW-1:0]            o_rd,
  output logic                     o_rbusy
);
  always_comb begin
    o_rd    = i_regs[i_ra];
    o_rbusy = i_busy[i_ra];
    if (BYPASS != 0) begin
      if (i_we1 && (i_wa1 == i_ra)) begin
        o_rd    = i_wd1;
        o_rbusy = 1'b0;
      end else if (i_we0 && (i_wa0 == i_ra)) begin
        o_rd    = i_wd0;
        o_rbusy = 1'b0;
      end
    end
    if ((ZERO_REG != 0) && (i_ra == AW'(REG_ZERO))) begin
      o_rd    = '0;
      o_rbusy = 1'b0;
    end
  end
endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports (port 1 wins collisions),
// NRD combinational read ports and a per-register pending-write scoreboard.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DW       = 32,
  parameter int DEPTH    = 32,
  parameter int NRD      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we0,
  input  logic [AW-1:0]       wa0,
  input  logic [DW-1:0]       wd0,
  input  logic                we1,
  input  logic [AW-1:0]       wa1,
  input  logic [DW-1:0]       wd1,
  input  logic [NRD*AW-1:0]   ra,
  output logic [NRD*DW-1:0]   rd,
  output logic [NRD-1:0]      rbusy,
  input  logic                iss_v,
  input  logic [AW-1:0]       iss_a,
  output logic [DEPTH-1:0]    busy_vec
);
  logic [DEPTH-1:0][DW-1:0] r_regs;
  logic [DEPTH-1:0]         r_busy;
  logic                     w_we0, w_we1, w_iss;

  // Qualified by reset so bypass cannot leak write data while reset is held.
  assign w_we0 = we0 && reset && !((ZERO_REG != 0) && (wa0 == AW'(REG_ZERO)));
  assign w_we1 = we1 && reset && !((ZERO_REG != 0) && (wa1 == AW'(REG_ZERO)));
  assign w_iss = iss_v && !((ZERO_REG != 0) && (iss_a == AW'(REG_ZERO)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_regs <= '0;
    end else begin
      if (w_we0) r_regs[wa0] <= wd0;
      if (w_we1) r_regs[wa1] <= wd1;
    end
  end

  // A same-cycle issue is younger than the retiring write, so set beats clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_busy <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_iss && (iss_a == AW'(i)))
          r_busy[i] <= 1'b1;
        else if ((w_we0 && (wa0 == AW'(i))) || (w_we1 && (wa1 == AW'(i))))
          r_busy[i] <= 1'b0;
      end
    end
  end

  assign busy_vec = r_busy;

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    regfile_rd_mux #(
      .DW(DW), .DEPTH(DEPTH), .AW(AW), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
    ) u_rd (
      .i_regs (r_regs),
      .i_busy (r_busy),
      .i_we0  (w_we0),
      .i_wa0  (wa0),
      .i_wd0  (wd0),
      .i_we1  (w_we1),
      .i_wa1  (wa1),
      .i_wd1  (wd1),
      .i_ra   (ra[k*AW +: AW]),
      .o_rd   (rd[k*DW +: DW]),
      .o_rbusy(rbusy[k])
    );
  end
endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a bypassing and a non-bypassing instance share the
// same stimulus and are checked every cycle against an array-based model.
module tb_regfile_mp;
  import regfile_mp_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        we0 = 1'b0, we1 = 1'b0, iss_v = 1'b0;
  logic [4:0]  wa0 = '0, wa1 = '0, iss_a = '0;
  logic [31:0] wd0 = '0, wd1 = '0;
  ra_bundle_t  ra = '0;
  logic [63:0] rd_b, rd_n;
  logic [1:0]  rbusy_b, rbusy_n;
  logic [31:0] busy_b, busy_n;

  int n_cmp = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  bit [31:0] m_regs [32];
  bit        m_busy [32];

  always #5 clk = ~clk;

  regfile_mp #(.BYPASS(1)) u_dut_b (
    .clk(clk), .reset(reset), .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1), .ra(ra), .rd(rd_b), .rbusy(rbusy_b),
    .iss_v(iss_v), .iss_a(iss_a), .busy_vec(busy_b)
  );

  regfile_mp #(.BYPASS(0)) u_dut_n (
    .clk(clk), .reset(reset), .we0(we0), .wa0(wa0), .wd0(wd0),
    .we1(we1), .wa1(wa1), .wd1(wd1), .ra(ra), .rd(rd_n), .rbusy(rbusy_n),
    .iss_v(iss_v), .iss_a(iss_a), .busy_vec(busy_n)
  );

  // Architectural model: writes in port order (later overwrites earlier),
  // retirement clears pending, then a younger issue re-marks it.
  always @(posedge clk) begin
    if (reset) begin
      if (we0 && wa0 != 0) m_regs[wa0] = wd0;
      if (we1 && wa1 != 0) m_regs[wa1] = wd1;
      if (we0) m_busy[wa0] = 1'b0;
      if (we1) m_busy[wa1] = 1'b0;
      if (iss_v && iss_a != 0) m_busy[iss_a] = 1'b1;
    end
  end

  always @(negedge reset) begin
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_busy[i] = 1'b0;
    end
  end

  function automatic logic [31:0] exp_rd(int a, bit byp);
    if (!reset || a == 0) return '0;
    if (byp && we1 && wa1 == a) return wd1;
    if (byp && we0 && wa0 == a) return wd0;
    return m_regs[a];
  endfunction

  function automatic logic exp_rbusy(int a, bit byp);
    if (!reset || a == 0) return 1'b0;
    if (byp && ((we1 && wa1 == a) || (we0 && wa0 == a))) return 1'b0;
    return m_busy[a];
  endfunction

  function automatic logic [31:0] exp_bvec();
    logic [31:0] v;
    for (int i = 0; i < 32; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("rd_byp[%0d]", k),   64'(rd_b[k*32 +: 32]), 64'(exp_rd(int'(ra[k]), 1'b1)));
        chk($sformatf("rd_nob[%0d]", k),   64'(rd_n[k*32 +: 32]), 64'(exp_rd(int'(ra[k]), 1'b0)));
        chk($sformatf("rbusy_byp[%0d]", k), 64'(rbusy_b[k]), 64'(exp_rbusy(int'(ra[k]), 1'b1)));
        chk($sformatf("rbusy_nob[%0d]", k), 64'(rbusy_n[k]), 64'(exp_rbusy(int'(ra[k]), 1'b0)));
      end
      chk("busy_vec_byp", 64'(busy_b), 64'(exp_bvec()));
      chk("busy_vec_nob", 64'(busy_n), 64'(exp_bvec()));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 1'b0; we1 = 1'b0; iss_v = 1'b0;
  endtask

  initial begin
    chk_en = 1'b1;
    // Random traffic while reset is held must leave no trace.
    for (int c = 0; c < 3; c++) begin
      we0 = 1'b1; wa0 = 5'($urandom_range(1, 31)); wd0 = $urandom;
      we1 = 1'b1; wa1 = 5'($urandom_range(1, 31)); wd1 = $urandom;
      iss_v = 1'b1; iss_a = 5'($urandom_range(1, 31));
      ra[0] = wa0; ra[1] = wa1;
      #2;
      chk("rst_rd0", 64'(rd_b[31:0]), 64'h0);
      chk("rst_rd1", 64'(rd_b[63:32]), 64'h0);
      chk("rst_bvec", 64'(busy_b), 64'h0);
      step();
    end
    idle();
    reset = 1'b1;
    for (int i = 0; i < 32; i++) begin
      ra[0] = 5'(i); ra[1] = 5'(31 - i);
      #1;
      chk("sweep_rd", 64'(rd_b), 64'h0);
      step();
    end

    // Basic write: bypass visible now, stored value visible next cycle.
    we0 = 1'b1; wa0 = 5'd5; wd0 = 32'hDEADBEEF; ra[0] = 5'd5;
    #1;
    chk("wr5_byp_same", 64'(rd_b[31:0]), 64'hDEADBEEF);
    chk("wr5_nob_same", 64'(rd_n[31:0]), 64'h0);
    step(); idle();
    chk("wr5_nob_next", 64'(rd_n[31:0]), 64'hDEADBEEF);

    // Collision on register 7: port 1 wins both storage and bypass.
    we0 = 1'b1; wa0 = 5'd7; wd0 = 32'h11;
    we1 = 1'b1; wa1 = 5'd7; wd1 = 32'h22; ra[0] = 5'd7;
    #1;
    chk("coll_byp_same", 64'(rd_b[31:0]), 64'h22);
    step(); idle();
    chk("coll_stored_b", 64'(rd_b[31:0]), 64'h22);
    chk("coll_stored_n", 64'(rd_n[31:0]), 64'h22);

    // Zero register ignores writes and issues.
    we0 = 1'b1; wa0 = 5'd0; wd0 = 32'hFFFFFFFF; iss_v = 1'b1; iss_a = 5'd0; ra[0] = 5'd0;
    #1;
    chk("zero_rd_same", 64'(rd_b[31:0]), 64'h0);
    chk("zero_rbusy_same", 64'(rbusy_b[0]), 64'h0);
    step(); idle();
    chk("zero_rd_next", 64'(rd_n[31:0]), 64'h0);
    chk("zero_busy0", 64'(busy_b[0]), 64'h0);

    // Scoreboard on register 9.
    ra[0] = 5'd9;
    iss_v = 1'b1; iss_a = 5'd9;            // t
    step(); idle();                        // t+1
    chk("sb9_set", 64'(busy_b[9]), 64'h1);
    chk("sb9_rbusy", 64'(rbusy_b[0]), 64'h1);
    step();                                // t+2
    step();                                // t+3
    we1 = 1'b1; wa1 = 5'd9; wd1 = 32'h99; iss_v = 1'b1; iss_a = 5'd9;
    #1;
    chk("sb9_byp_rbusy", 64'(rbusy_b[0]), 64'h0);
    chk("sb9_nob_rbusy", 64'(rbusy_n[0]), 64'h1);
    step(); idle();                        // t+4
    chk("sb9_kept", 64'(busy_b[9]), 64'h1);
    step();                                // t+5
    we0 = 1'b1; wa0 = 5'd9; wd0 = 32'h5A;
    step(); idle();                        // t+6
    chk("sb9_clr", 64'(busy_b[9]), 64'h0);
    chk("sb9_data", 64'(rd_n[31:0]), 64'h5A);

    // Asynchronous reset between edges during a write to register 3.
    iss_v = 1'b1; iss_a = 5'd3;
    step(); idle();
    chk("ar_busy_pre", 64'(busy_b[3]), 64'h1);
    we0 = 1'b1; wa0 = 5'd3; wd0 = 32'hABCD; ra[0] = 5'd3;
    #2 reset = 1'b0;
    #1;
    chk("ar_bvec_now", 64'(busy_b), 64'h0);
    chk("ar_rd_byp", 64'(rd_b[31:0]), 64'h0);
    step();
    idle();
    reset = 1'b1;
    #1;
    chk("ar_reg3_b", 64'(rd_b[31:0]), 64'h0);
    chk("ar_reg3_n", 64'(rd_n[31:0]), 64'h0);

    // Random traffic on a small address set to stress collisions and bypass.
    for (int c = 0; c < 300; c++) begin
      step();
      we0 = 1'($urandom_range(0, 1)); wa0 = 5'($urandom_range(0, 7)); wd0 = $urandom;
      we1 = 1'($urandom_range(0, 1)); wa1 = 5'($urandom_range(0, 7)); wd1 = $urandom;
      iss_v = 1'($urandom_range(0, 1)); iss_a = 5'($urandom_range(0, 7));
      ra[0] = 5'($urandom_range(0, 7)); ra[1] = 5'($urandom_range(0, 7));
    end
    step(); idle();
    step();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Next-generation general-purpose register file for the pipelined CPU.
- Generalised in data width, depth and read-port count; two write ports (e.g. ALU/MEM retire and late load retire).
- Optional same-cycle write-to-read bypass.
- Per-register pending-write scoreboard that the hazard unit uses for stall decisions.

Parameters:
- DW, 32, data width in bits
- DEPTH, 32, number of registers (power of two, >=2)
- AW, $clog2(DEPTH), address width (derived, not overridden)
- NRD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = read ports see same-cycle write data; 0 = read returns stored value only
- ZERO_REG, 1, 1 = register 0 is hardwired zero and never busy

Ports:
- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-low reset (0 = reset asserted)
- we0  in  1  write enable, port 0
- wa0  in  AW  write address, port 0
- wd0  in  DW  write data, port 0
- we1  in  1  write enable, port 1 (higher priority)
- wa1  in  AW  write address, port 1
- wd1  in  DW  write data, port 1
- ra  in  NRD*AW  packed read addresses, port k at [k*AW +: AW]
- rd  out  NRD*DW  packed read data, port k at [k*DW +: DW]
- rbusy  out  NRD  rbusy[k] = register at ra[k] has an outstanding write
- iss_v  in  1  issue: mark register iss_a pending
- iss_a  in  AW  register to mark pending
- busy_vec  out  DEPTH  raw scoreboard bits, for debug/trace

Behaviour:
- Reset (reset=0, asynchronous):
  - All registers clear to 0; all busy bits clear.
  - While reset is held, rd = 0 for every read port (all registers 0), rbusy = 0, busy_vec = 0.
  - Reset asserted mid-operation discards any write in that cycle.
- Write timing: on rising clk with reset=1, for each port with weN=1, regfile[waN] <= wdN.
- Write collision: we0 and we1 both 1 with wa0 == wa1 -> port 1 value stored; port 0 dropped.
- ZERO_REG=1: writes to address 0 are ignored; reads of address 0 return 0.
- Read timing: combinational, zero latency.
  - BYPASS=1 and the read address matches an active write port (address != 0 when ZERO_REG=1): rd returns that port's write data.
  - Both write ports match the read address: port 1 data is returned.
  - Otherwise rd returns the stored value.
  - BYPASS=0: rd always returns the stored value, so new data is visible the cycle after the write.
- Scoreboard, one bit per register, updated on rising clk:
  - iss_v=1 sets busy[iss_a].
  - Any active write to address a clears busy[a].
  - Same-cycle issue and write to the same address: busy stays 1 (the issue is younger).
  - Issue to address 0 with ZERO_REG=1 is ignored.
- rbusy[k] = busy[ra[k]], except:
  - With BYPASS=1, rbusy[k] = 0 when a same-cycle write hits ra[k].
  - With ZERO_REG=1, rbusy[k] = 0 for address 0.
- Out-of-range addresses cannot occur (DEPTH is a power of two).
- No other state exists; the block never stalls and has no handshake beyond the enables.

Decomposition:
- Shared CPU package holds:
  - the register-address width constant;
  - register-index constants used by decode (ZERO = 0, RA = 31);
  - a typedef for the packed read-port bundle.
- One natural sub-module, regfile_rd_mux: a single read port containing the stored-value mux, bypass compare, priority selection and rbusy gating.
  - The top instantiates regfile_rd_mux NRD times in a generate loop.
- Storage, write-collision logic and scoreboard stay in the top.

Test Plan:
- Reset and idle: hold reset=0 3 cycles after random writes -> every rd=0, busy_vec=0; release, read all 32 registers -> all 0.
- Basic write then read: we0=1, wa0=5, wd0=0xDEADBEEF -> with BYPASS=1 rd[0] (ra=5) = 0xDEADBEEF in the same cycle; with BYPASS=0 it reads 0 that cycle and 0xDEADBEEF the next.
- Write collision: we0=we1=1, wa0=wa1=7, wd0=0x11, wd1=0x22 -> register 7 = 0x22; the bypassed same-cycle read also shows 0x22.
- Zero register: write 0xFFFFFFFF to address 0 and issue iss_a=0 -> rd=0, rbusy=0, busy_vec[0]=0.
- Scoreboard sequence on register 9:
  - iss_v, iss_a=9 at cycle t -> busy_vec[9]=1 from t+1.
  - At t+3, we1=1, wa1=9 together with iss_a=9 -> busy_vec[9] stays 1, and rbusy=0 in that cycle (bypass).
  - Write at t+5 with no issue -> busy_vec[9]=0 from t+6.
- Asynchronous reset mid-write: drop reset between clock edges while we0=1, wa0=3 -> register 3 stays 0 and busy clears immediately, without waiting for a clock edge.
